updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter_if.sv | 23 ++
 rtl/updown_mod_counter.sv | 63 ++++++
 tb/tb_updown_mod_counter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
// The master drives the control signals. The slave (the counter) drives count, tc and wrap.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  count, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, tc, wrap
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Modulo-MODULUS up/down counter with parallel load, terminal count and rollover pulse.
// Define UPDOWN_COUNTER_SATURATE_EN to make the counter saturate at the range ends instead of wrapping.
module updown_mod_counter #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  updown_mod_counter_if.slave bus
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be in 2..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_end;

  // at_end is the terminal count for the current direction.
  always_comb begin
    at_end = bus.up_dn ? (count_q == MAX) : (count_q == '0);
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      count_d = (64'(bus.load_val) >= MODULUS) ? MAX : bus.load_val;
    end else if (bus.en) begin
      if (!at_end) begin
        count_d = bus.up_dn ? count_q + 1'b1 : count_q - 1'b1;
      end else begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
        count_d = count_q;
`else
        count_d = bus.up_dn ? '0 : MAX;
        wrap_d  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = at_end;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter, covering a MODULUS=16 and a MODULUS=10 instance.
// The expected values follow the build, including the UPDOWN_COUNTER_SATURATE_EN build.
module tb_updown_mod_counter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(4)) b16 ();
  updown_mod_counter_if #(.WIDTH(4)) b10 ();

  updown_mod_counter #(.WIDTH(4), .MODULUS(16)) u16 (.clk_i(clk), .rst_ni(rst_n), .bus(b16));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10)) u10 (.clk_i(clk), .rst_ni(rst_n), .bus(b10));

`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_c;
  bit exp_w;

  initial begin
    rst_n = 1'b0;
    b16.en = 0; b16.up_dn = 1; b16.load = 0; b16.load_val = '0;
    b10.en = 0; b10.up_dn = 0; b10.load = 0; b10.load_val = '0;

    // Reset for two cycles; tc follows up_dn during reset.
    step(); step();
    chk("rst_count16", b16.count, 0);
    chk("rst_wrap16", b16.wrap, 0);
    chk("rst_tc_up", b16.tc, 0);
    chk("rst_tc_dn10", b10.tc, 1);
    b16.up_dn = 0; #1;
    chk("rst_tc_dn16", b16.tc, 1);
    b16.up_dn = 1; #1;

    // Count up for 17 cycles: 1..15, then 0 (or hold at 15 when saturating).
    rst_n = 1'b1;
    b16.en = 1;
    for (int i = 1; i <= 17; i++) begin
      step();
      if (SAT) begin
        exp_c = (i > 15) ? 15 : i;
        exp_w = 1'b0;
      end else begin
        exp_c = i % 16;
        exp_w = (i == 16);
      end
      chk($sformatf("up16_count_%0d", i), b16.count, exp_c);
      chk($sformatf("up16_wrap_%0d", i), b16.wrap, exp_w);
      chk($sformatf("up16_tc_%0d", i), b16.tc, (exp_c == 15));
    end

    // Load takes priority over en and ignores direction.
    b16.load = 1; b16.load_val = 4'd7; b16.up_dn = 0;
    step();
    chk("load7_count", b16.count, 7);
    chk("load7_wrap", b16.wrap, 0);
    b16.load_val = 4'd12;
    step();
    chk("load12_m16", b16.count, 12);
    b16.load = 0; b16.en = 0;
    step(); step();
    chk("hold_count", b16.count, 12);

    // Reset overrides load and en in the middle of a count.
    b16.load = 1; b16.load_val = 4'd5;
    step();
    chk("load5", b16.count, 5);
    rst_n = 0; b16.en = 1; b16.load_val = 4'd9;
    step();
    chk("rst_mid_count", b16.count, 0);
    chk("rst_mid_wrap", b16.wrap, 0);
    rst_n = 1; b16.load = 0; b16.up_dn = 1;
    step();
    chk("post_rst_first", b16.count, 1);

    // Change direction at count 3 while en stays high: 2,3,2,1.
    b16.load = 1; b16.load_val = 4'd2;
    step();
    chk("dir_start", b16.count, 2);
    b16.load = 0; b16.up_dn = 1;
    step();
    chk("dir_up3", b16.count, 3);
    b16.up_dn = 0;
    step();
    chk("dir_dn2", b16.count, 2);
    step();
    chk("dir_dn1", b16.count, 1);
    step();
    chk("dir_dn0", b16.count, 0);
    chk("dir_tc0", b16.tc, 1);
    step();
    chk("dn16_wrap_count", b16.count, SAT ? 0 : 15);
    chk("dn16_wrap_pulse", b16.wrap, SAT ? 0 : 1);
    b16.en = 0;
    step();
    chk("wrap_one_cycle", b16.wrap, 0);

    // Count down the MODULUS=10 instance from 0: 9,8,7 (or hold at 0).
    b10.en = 1; b10.up_dn = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_c = SAT ? 0 : 10 - i;
      exp_w = SAT ? 1'b0 : (i == 1);
      chk($sformatf("dn10_count_%0d", i), b10.count, exp_c);
      chk($sformatf("dn10_wrap_%0d", i), b10.wrap, exp_w);
    end

    // A load_val at or above MODULUS loads MODULUS-1.
    b10.load = 1; b10.load_val = 4'd12;
    step();
    chk("load12_m10", b10.count, 9);
    chk("load12_m10_wrap", b10.wrap, 0);
    b10.load_val = 4'd10;
    step();
    chk("load10_m10", b10.count, 9);
    b10.load = 0; b10.up_dn = 1;
    #1;
    chk("tc10_up9", b10.tc, 1);
    step();
    chk("up10_roll", b10.count, SAT ? 9 : 0);
    chk("up10_wrap", b10.wrap, SAT ? 0 : 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
